divider_32: RTL
===============

# divider_32

Sequential signed 32-bit integer divider: the inverse-operation companion to the ALU's sequential multiplier. It uses a radix-2 restoring algorithm on operand magnitudes, one quotient bit per clock, then applies a sign fix-up. It sits in the ALU beside the multiplier and shares its start/enable/done handshake, so the ALU sequencer drives both the same way.

## Interface

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state and outputs immediately.
- ena  in  1  clock enable; when low, all state holds, including the iteration counter and outputs, and str is ignored.
- str  in  1  start; sampled at a rising edge with ena=1, it captures a and b and begins an operation.
- a  in  32  signed dividend.
- b  in  32  signed divisor.
- q  out  32  signed quotient, registered.
- r  out  32  signed remainder, registered.
- dne  out  1  result valid; held until the next accepted str or reset.
- dbz  out  1  divide-by-zero flag; valid while dne=1.

## Operation

- States:
  - IDLE: after reset.
  - CALC: WIDTH iterations.
  - FIX: sign correction and output load.
  - DONE: result held.
- Accepted str (any state, including mid-CALC) does all of the following:
  - Latches |a|, |b|, sign_q = a[31]^b[31], sign_r = a[31].
  - Clears the counter, dne and dbz.
  - Enters CALC, or FIX if b==0.
  - A restart mid-operation discards the old operation; q and r keep their previous values until the new FIX.
- CALC iteration: shift {rem, dividend} left 1. If rem >= |b|, then rem -= |b| and set the new quotient bit to 1; otherwise set it to 0. The counter increments; after iteration WIDTH-1 the block goes to FIX.
- Magnitude datapath is 33 bits wide, so |0x80000000| = 2^31 is handled exactly.
- FIX:
  - q = sign_q ? -qmag : qmag.
  - r = sign_r ? -rmag : rmag.
  - All arithmetic is modulo 2^32.
  - Sets dne=1 and enters DONE.
- Semantics: quotient truncates toward zero, and the remainder takes the sign of the dividend, so a == q*b + r always holds (mod 2^32).
- Overflow: 0x80000000 / -1 gives q=0x80000000, r=0, dbz=0 (natural wrap; no flag).
- Divide by zero (b==0): q=0xFFFFFFFF, r=a, dbz=1, dne=1.
- DONE: outputs stable; only str or rst leaves this state.

## Timing

- Reset values: q=0, r=0, dne=0, dbz=0, state IDLE, counter 0.
- Latency, counting enabled edges after the str capture edge E0:
  - Normal: E1..E32 are the iterations; E33 loads q/r and sets dne. dne is visible after E33, i.e. 33 cycles.
  - b==0: E1 loads outputs and sets dne=1, dbz=1.
- Each cycle with ena=0 adds exactly one cycle to latency; no state changes during it.
- dne deasserts on the edge that accepts str.
- str and ena=1 at the edge where FIX would complete: the restart wins, and no result is loaded.
- Reset asserted at any time: outputs go to their reset values without waiting for a clock. After release, the first accepted str behaves normally.
- No back-pressure: the result is held indefinitely in DONE.

## Structure

- Shared ALU package holds:
  - WIDTH default;
  - state encoding constants (IDLE, CALC, FIX, DONE);
  - divide-by-zero quotient constant (all ones).
- One sub-module, divider_step: combinational single restoring iteration.
  - Inputs: 33-bit rem, dividend MSB, |b|.
  - Outputs: next rem and quotient bit.
- Top level holds the FSM, counter, magnitude/sign capture and fix-up.
- Bench reads a vector file with lines "a b : q r", the same style as the multiplier vectors.

## Test plan

- 100 / 7 -> q=14, r=2, dbz=0; dne rises exactly 33 cycles after the str edge.
- -100 / 7 -> q=-14, r=-2; and 7 / -100 -> q=0, r=7.
- 0x80000000 / -1 -> q=0x80000000, r=0, dbz=0; and 0x80000000 / 1 -> q=0x80000000, r=0.
- 5 / 0 -> q=0xFFFFFFFF, r=5, dbz=1, dne one cycle after str; then 9 / 3 -> dbz=0, q=3, r=0 at 33 cycles.
- 1000 / 3 with ena=0 for 5 cycles mid-CALC -> q=333, r=1, dne at 38 cycles; a new str (50/5) at iteration 10 restarts -> q=10, r=0 at 33 cycles from the restart.
- rst asserted between edges at iteration 20 -> q, r, dne, dbz are 0 before the next edge; after release, -7 / 2 -> q=-3, r=-1.

Source files
------------

// File: rtl/divider_32_pkg.sv
// Shared ALU definitions for the sequential divider: width default, FSM
// state encoding and the divide-by-zero quotient pattern.
package divider_32_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/divider_32_step.sv
// One restoring-division iteration on magnitudes: shift in the next dividend
// bit, subtract the divisor when it fits, and report the quotient bit.
module divider_32_step
    import divider_32_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0] rem,
    input  logic           din,
    input  logic [WIDTH:0] bmag,
    output logic [WIDTH:0] rem_nxt,
    output logic           qbit
);

    logic [WIDTH:0] shifted;
    logic           ovf;

    always_comb begin
        shifted = {rem[WIDTH-1:0], din};
        ovf     = rem[WIDTH];
        qbit    = ovf | (shifted >= bmag);
        rem_nxt = qbit ? (shifted - bmag) : shifted;
    end

endmodule

// File: rtl/divider_32.sv
// Sequential signed divider: one restoring iteration per enabled clock on
// operand magnitudes, followed by a sign fix-up cycle.
module divider_32
    import divider_32_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             str,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dne,
    output logic             dbz
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_t     state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] bmag;
    logic [WIDTH-1:0] dvd;
    logic           sign_q, sign_r, bz;

    logic [WIDTH:0] amag_in, bmag_in;
    logic [WIDTH:0] rem_nxt;
    logic           qbit;

    always_comb begin
        amag_in = {1'b0, (a[WIDTH-1] ? -a : a)};
        bmag_in = {1'b0, (b[WIDTH-1] ? -b : b)};
    end

    divider_32_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .din     (dvd[WIDTH-1]),
        .bmag    (bmag),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ena) begin
            if (str) begin
                state_nxt = (b == '0) ? FIX : CALC;
            end else begin
                case (state)
                    CALC:    if (cnt == LAST) state_nxt = FIX;
                    FIX:     state_nxt = DONE;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // dvd doubles as the quotient shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            rem    <= '0;
            bmag   <= '0;
            dvd    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            bz     <= 1'b0;
            q      <= '0;
            r      <= '0;
            dne    <= 1'b0;
            dbz    <= 1'b0;
        end else if (ena) begin
            if (str) begin
                cnt    <= '0;
                dne    <= 1'b0;
                dbz    <= 1'b0;
                sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                sign_r <= a[WIDTH-1];
                bmag   <= bmag_in;
                dvd    <= amag_in[WIDTH-1:0];
                bz     <= (b == '0);
                // With a zero divisor |a| is parked in rem so the usual
                // remainder fix-up reproduces a exactly.
                rem    <= (b == '0) ? amag_in : '0;
            end else begin
                case (state)
                    CALC: begin
                        rem <= rem_nxt;
                        dvd <= {dvd[WIDTH-2:0], qbit};
                        cnt <= cnt + CW'(1);
                    end
                    FIX: begin
                        q   <= bz ? DBZ_QUOT : (sign_q ? -dvd : dvd);
                        r   <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                        dne <= 1'b1;
                        dbz <= bz;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
